fault_response_monitor: RTL and testbench
=========================================

# fault_response_monitor

Downstream checker for the fault-injection campaign on the `sin` netlist. For each fault pass it samples the DUT's 25-bit output once per stimulus step and compares each sample against the golden output for that step. It reports one result record per fault ID over a valid/ready handshake: detection flag, first failing step, mismatch count and an optional MISR signature. It sits between the DUT outputs (plus golden model) and the campaign result logger.

## Interface
Parameters:
- `DW`, 25, observed output width (`sin[24:0]`)
- `STEPS`, 128, samples per fault pass; legal range 2..254
- `FIDW`, 16, fault-ID width
- `CNTW`, 8, mismatch counter width; the counter saturates
- `POLY`, 25'h0000009, MISR feedback polynomial (x^25+x^3+1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse that opens a pass; sampled only in IDLE
- `fid`  in  FIDW  fault ID of the pass; captured with `start`
- `obs_valid`  in  1  DUT sample and golden sample are valid this cycle
- `obs_data`  in  DW  DUT output sample
- `gold_data`  in  DW  golden output sample for the same step
- `busy`  out  1  high in RUN and REPORT
- `res_valid`  out  1  result record valid
- `res_ready`  in  1  result consumer accepts the record
- `res_fid`  out  FIDW  fault ID of the record
- `res_detected`  out  1  at least one mismatch occurred in the pass
- `res_first_step`  out  8  index of the first mismatching sample; 8'hFF if none
- `res_mismatch_cnt`  out  CNTW  number of mismatching samples, saturating
- `res_signature`  out  DW  final MISR value (see Configuration)

## Operation
- States: IDLE, RUN, REPORT.
- IDLE, `start`=1 → RUN. On entry:
  - latch `fid`
  - step counter=0, mismatch count=0
  - first_step=8'hFF, detected=0, signature=0
- RUN, each cycle with `obs_valid`=1:
  - `miss` = (`obs_data` != `gold_data`)
  - if `miss`: count += 1, saturating at 2^CNTW-1; detected=1
  - if `miss` and first_step==8'hFF: first_step = step counter
  - MISR update: sig ← {sig[DW-2:0],1'b0} ^ (sig[DW-1] ? POLY : 0) ^ obs_data
  - step counter += 1
- RUN, the sample with step counter == STEPS-1 is accepted → REPORT on the next edge.
- RUN, `obs_valid`=0: nothing changes; there is no timeout.
- REPORT: `res_valid`=1, and all `res_*` outputs are stable. On `res_valid`&&`res_ready` → IDLE.
- Ignored events:
  - `start` in RUN or REPORT has no effect; the fault ID is not re-captured.
  - `obs_valid` in IDLE or REPORT has no effect.
- `start` in the same cycle that REPORT is left is ignored. The earliest next start is one cycle later, in IDLE.
- Reset at any point, including mid-RUN or in REPORT with `res_valid` high:
  - state → IDLE
  - the partial pass is discarded; no record is emitted
- Reset values:
  - `busy`=0, `res_valid`=0
  - `res_fid`=0, `res_detected`=0
  - `res_first_step`=8'hFF, `res_mismatch_cnt`=0, `res_signature`=0

## Timing
- `start` at edge N → `busy`=1 after edge N. The first sample is accepted at edge N+1 at the earliest.
- The last sample is accepted at edge M → `res_valid`=1 after edge M, i.e. 1 cycle of latency.
- With `obs_valid` held high, a pass takes STEPS+1 cycles from `start` to `res_valid`, with `res_ready` tied high.
- `res_ready` may be high before `res_valid`. The handshake completes in the first cycle both are high.
- `res_*` outputs are registered. They change only on pass start and during RUN, never while `res_valid`=1.
- Mismatch compare is combinational on the inputs in the sampling cycle. There is no input registering.

## Configuration
- `FRM_MISR_EN` defined:
  - the MISR register and its update logic are built
  - `res_signature` carries the final MISR value
- `FRM_MISR_EN` undefined:
  - no MISR flops are built
  - `res_signature` is constant 0
  - all other behaviour is identical

## Test plan
- Golden == obs on all 128 samples, fid=16'h0005 → record fid=5, detected=0, first_step=8'hFF, cnt=0.
- Mismatches at steps 3, 7 and 100, fid=16'h0A2C → detected=1, first_step=3, cnt=3.
- All 128 samples mismatch with CNTW=4 → cnt saturates at 15; first_step=0.
- `obs_valid` toggled every other cycle → the record appears after exactly 128 accepted samples. `start` pulses mid-RUN are ignored, so `res_fid` keeps the first ID.
- `res_ready` held low for 10 cycles in REPORT → `res_valid` and all `res_*` fields hold steady. `obs_valid` pulses during REPORT have no effect. The record is accepted when `res_ready` rises.
- Reset asserted at step 60 → `busy`=0 and `res_first_step`=8'hFF immediately, with no record emitted. The following pass with no mismatches reports cnt=0.
- With `FRM_MISR_EN`, single sample obs=25'h0000001 then 127 zero samples → signature equals the software MISR model's value (sig=1 shifted 127 times through POLY). Without the macro → signature=0.

Source files
------------

// File: rtl/fault_response_monitor.sv
// fault_response_monitor
// Per-fault-pass output checker for the fault-injection campaign. Compares
// each accepted DUT sample against its golden sample, tracks detection,
// first failing step and a saturating mismatch count, and hands one result
// record per fault ID to the logger over a valid/ready handshake.
// Optional feature: define FRM_MISR_EN to build the MISR signature register;
// without it res_signature is tied to zero.

module fault_response_monitor #(
  parameter int              DW    = 25,
  parameter int              STEPS = 128,
  parameter int              FIDW  = 16,
  parameter int              CNTW  = 8,
  parameter logic [DW-1:0]   POLY  = 'h0000009
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [FIDW-1:0] fid,
  input  logic            obs_valid,
  input  logic [DW-1:0]   obs_data,
  input  logic [DW-1:0]   gold_data,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [FIDW-1:0] res_fid,
  output logic            res_detected,
  output logic [7:0]      res_first_step,
  output logic [CNTW-1:0] res_mismatch_cnt,
  output logic [DW-1:0]   res_signature
);

  // IDLE   : waiting for a start pulse; record fields hold the last result
  // RUN    : accepting samples, record fields accumulate in place
  // REPORT : record frozen, res_valid high until the logger accepts it
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [7:0]      LAST_STEP = 8'(STEPS - 1);
  localparam logic [7:0]      NO_STEP   = 8'hFF;
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

  state_t          state_q;
  logic [7:0]      step_q;
  logic            busy_q;
  logic            res_valid_q;
  logic [FIDW-1:0] fid_q;
  logic            det_q;
  logic [7:0]      first_q;
  logic [CNTW-1:0] cnt_q;

  logic            miss;
  logic [CNTW-1:0] cnt_d;
  logic [7:0]      step_d;

  // Compare is purely combinational on the sampling-cycle inputs.
  assign miss   = (obs_data != gold_data);
  assign cnt_d  = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);
  assign step_d = step_q + 8'd1;

  // Pass sequencing; record fields double as the working accumulators so
  // they stay frozen once REPORT is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= 8'd0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      fid_q       <= '0;
      det_q       <= 1'b0;
      first_q     <= NO_STEP;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            fid_q   <= fid;
            step_q  <= 8'd0;
            det_q   <= 1'b0;
            first_q <= NO_STEP;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          if (obs_valid) begin
            if (miss) begin
              cnt_q <= cnt_d;
              det_q <= 1'b1;
              if (first_q == NO_STEP) first_q <= step_q;
            end
            step_q <= step_d;
            if (step_q == LAST_STEP) begin
              state_q     <= S_REPORT;
              res_valid_q <= 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign res_valid        = res_valid_q;
  assign res_fid          = fid_q;
  assign res_detected     = det_q;
  assign res_first_step   = first_q;
  assign res_mismatch_cnt = cnt_q;

`ifdef FRM_MISR_EN
  logic [DW-1:0] sig_q;
  logic [DW-1:0] sig_d;
  logic          sig_clr;
  logic          sig_en;

  assign sig_clr = (state_q == S_IDLE) && start;
  assign sig_en  = (state_q == S_RUN) && obs_valid;

  // Next MISR value: shift, fold back the polynomial on MSB, absorb sample.
  always_comb begin
    sig_d = {sig_q[DW-2:0], 1'b0} ^ obs_data;
    if (sig_q[DW-1]) sig_d = sig_d ^ POLY;
  end

  // Signature register, cleared when a pass opens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if (sig_clr) begin
      sig_q <= '0;
    end else if (sig_en) begin
      sig_q <= sig_d;
    end
  end

  assign res_signature = sig_q;
`else
  assign res_signature = '0;
`endif

endmodule

// File: tb/tb_fault_response_monitor.sv
// Self-checking bench for fault_response_monitor. A second instance with a
// 4-bit mismatch counter shares all inputs to exercise saturation.
`timescale 1ns/1ps

module tb_fault_response_monitor;

  localparam int DW    = 25;
  localparam int STEPS = 128;
  localparam int FIDW  = 16;
  localparam int RECW  = FIDW + 1 + 8 + 8 + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [FIDW-1:0] fid;
  logic            obs_valid;
  logic [DW-1:0]   obs_data;
  logic [DW-1:0]   gold_data;
  logic            res_ready;

  logic            busy, res_valid, res_detected;
  logic [FIDW-1:0] res_fid;
  logic [7:0]      res_first_step, res_mismatch_cnt;
  logic [DW-1:0]   res_signature;

  logic            busy4, res_valid4, res_detected4;
  logic [FIDW-1:0] res_fid4;
  logic [7:0]      res_first_step4;
  logic [3:0]      res_mismatch_cnt4;
  logic [DW-1:0]   res_signature4;

  fault_response_monitor dut (
    .clk(clk), .rst(rst), .start(start), .fid(fid), .obs_valid(obs_valid),
    .obs_data(obs_data), .gold_data(gold_data), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_fid(res_fid), .res_detected(res_detected),
    .res_first_step(res_first_step), .res_mismatch_cnt(res_mismatch_cnt),
    .res_signature(res_signature)
  );

  fault_response_monitor #(.CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .fid(fid), .obs_valid(obs_valid),
    .obs_data(obs_data), .gold_data(gold_data), .busy(busy4), .res_valid(res_valid4),
    .res_ready(res_ready), .res_fid(res_fid4), .res_detected(res_detected4),
    .res_first_step(res_first_step4), .res_mismatch_cnt(res_mismatch_cnt4),
    .res_signature(res_signature4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] obs_a  [STEPS];
  logic [DW-1:0] gold_a [STEPS];

  // expected record from the reference model
  logic [RECW-1:0] e_rec;
  logic [3:0]      e_cnt4;
  // observed record and protocol flags from the driver
  logic [RECW-1:0] r_rec;
  logic [3:0]      r_cnt4;
  bit start_busy_ok, lat_ok, valid_at_m, hold_ok, done_ok;

  function automatic logic [RECW-1:0] dut_rec();
    return {res_fid, res_detected, res_first_step, res_mismatch_cnt, res_signature};
  endfunction

  // ---------------- stimulus generation ----------------
  function automatic logic [DW-1:0] rnd_word();
    return DW'($urandom);
  endfunction

  function automatic logic [DW-1:0] flip(input logic [DW-1:0] w);
    logic [DW-1:0] one;
    one = 1;
    return w ^ (one << $urandom_range(0, DW-1));
  endfunction

  task automatic fill_equal();
    for (int k = 0; k < STEPS; k++) begin
      gold_a[k] = rnd_word();
      obs_a[k]  = gold_a[k];
    end
  endtask

  // ---------------- reference model ----------------
  // Derived from the pass rules: count differing samples, note the first,
  // and fold every sample through a 25-bit MISR using integer arithmetic.
  task automatic model(input logic [FIDW-1:0] f);
    int          n;
    logic [7:0]  first;
    longint      s;
    longint      mask;
    logic [DW-1:0] sig;
    n = 0; first = 8'hFF; s = 0;
    mask = (longint'(1) << DW) - 1;
    for (int k = 0; k < STEPS; k++) begin
      if (obs_a[k] != gold_a[k]) begin
        if (n == 0) first = k[7:0];
        n++;
      end
      s = ((s * 2) & mask) ^ (((s >> (DW-1)) & 1) != 0 ? longint'(9) : longint'(0))
          ^ longint'(obs_a[k]);
    end
`ifdef FRM_MISR_EN
    sig = s[DW-1:0];
`else
    sig = '0;
`endif
    e_rec  = {f, (n != 0), first, 8'((n > 255) ? 255 : n), sig};
    e_cnt4 = 4'((n > 15) ? 15 : n);
  endtask

  // ---------------- pass driver ----------------
  // Starts and ends at posedge+1. gaps: idle cycle before every sample;
  // noise: random start pulses in RUN/REPORT; hold: cycles res_ready stays
  // low in REPORT (0 = ready high from the start); exit_start: pulse start
  // in the handshake cycle.
  task automatic run_pass(input logic [FIDW-1:0] f, input bit gaps, input bit noise,
                          input int hold, input bit exit_start);
    logic [RECW-1:0] snap;
    lat_ok = 1; hold_ok = 1; done_ok = 1;
    res_ready = (hold == 0);
    start = 1'b1; fid = f;
    @(posedge clk); #1;
    start = 1'b0; fid = FIDW'($urandom);
    start_busy_ok = (busy === 1'b1) && (res_valid === 1'b0);
    for (int i = 0; i < STEPS; i++) begin
      if (gaps) begin
        obs_valid = 1'b0; obs_data = rnd_word(); gold_data = ~obs_data;
        start = noise ? 1'($urandom) : 1'b0;
        @(posedge clk); #1;
        if (res_valid !== 1'b0) lat_ok = 0;
      end
      obs_valid = 1'b1; obs_data = obs_a[i]; gold_data = gold_a[i];
      start = noise ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      if (i < STEPS-1 && res_valid !== 1'b0) lat_ok = 0;
    end
    obs_valid = 1'b0;
    valid_at_m = (res_valid === 1'b1) && (res_valid4 === 1'b1);
    r_rec  = dut_rec();
    r_cnt4 = res_mismatch_cnt4;
    snap   = r_rec;
    for (int h = 0; h < hold; h++) begin
      obs_valid = 1'($urandom); obs_data = rnd_word(); gold_data = rnd_word();
      start = noise ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || dut_rec() !== snap || res_mismatch_cnt4 !== r_cnt4) hold_ok = 0;
    end
    obs_valid = 1'b0; start = exit_start; fid = FIDW'($urandom);
    res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (res_valid !== 1'b0 || busy !== 1'b0 || dut_rec() !== snap) done_ok = 0;
    res_ready = 1'b0;
    @(posedge clk); #1;
    if (busy !== 1'b0 || res_valid !== 1'b0) done_ok = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 0; fid = 0; obs_valid = 0; obs_data = 0; gold_data = 0; res_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, res_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl busy/valid=%b required 00", {busy, res_valid});
    end
    checks++;
    if (dut_rec() !== {16'h0, 1'b0, 8'hFF, 8'h00, 25'h0}) begin
      errors++;
      $display("FAIL reset_rec got=%h required=%h", dut_rec(), {16'h0, 1'b0, 8'hFF, 8'h00, 25'h0});
    end
    checks++;
    if (res_mismatch_cnt4 !== 4'h0) begin
      errors++;
      $display("FAIL reset_cnt4 got=%h required=0", res_mismatch_cnt4);
    end
  endtask

  task automatic test_clean();
    fill_equal();
    model(16'h0005);
    run_pass(16'h0005, 0, 0, 0, 0);
    checks++;
    if (r_rec !== e_rec) begin
      errors++;
      $display("FAIL clean_rec got=%h required=%h", r_rec, e_rec);
    end
    checks++;
    if (!(start_busy_ok && lat_ok && valid_at_m && done_ok)) begin
      errors++;
      $display("FAIL clean_timing got=%b%b%b%b required=1111", start_busy_ok, lat_ok, valid_at_m, done_ok);
    end
  endtask

  task automatic test_mismatch_list();
    fill_equal();
    obs_a[3] = flip(gold_a[3]); obs_a[7] = flip(gold_a[7]); obs_a[100] = flip(gold_a[100]);
    model(16'h0A2C);
    run_pass(16'h0A2C, 0, 0, 0, 0);
    checks++;
    if (r_rec !== e_rec) begin
      errors++;
      $display("FAIL list_rec got=%h required=%h", r_rec, e_rec);
    end
    checks++;
    if ({r_rec[DW+16], r_rec[DW+15 -: 8], r_rec[DW+7 -: 8]} !== {1'b1, 8'd3, 8'd3}) begin
      errors++;
      $display("FAIL list_fields det/first/cnt=%h required=10303",
               {r_rec[DW+16], r_rec[DW+15 -: 8], r_rec[DW+7 -: 8]});
    end
  endtask

  task automatic test_saturate();
    fill_equal();
    for (int k = 0; k < STEPS; k++) obs_a[k] = flip(gold_a[k]);
    model(16'hBEEF);
    run_pass(16'hBEEF, 0, 0, 0, 0);
    checks++;
    if (r_rec !== e_rec) begin
      errors++;
      $display("FAIL sat_rec got=%h required=%h", r_rec, e_rec);
    end
    checks++;
    if (r_cnt4 !== e_cnt4 || e_cnt4 !== 4'd15) begin
      errors++;
      $display("FAIL sat_cnt4 got=%0d required=%0d", r_cnt4, e_cnt4);
    end
  endtask

  task automatic test_gaps_midstart();
    fill_equal();
    for (int k = 0; k < STEPS; k++) if ($urandom_range(0, 7) == 0) obs_a[k] = flip(gold_a[k]);
    model(16'h1234);
    run_pass(16'h1234, 1, 1, 0, 0);
    checks++;
    if (r_rec !== e_rec) begin
      errors++;
      $display("FAIL gaps_rec got=%h required=%h", r_rec, e_rec);
    end
    checks++;
    if (r_cnt4 !== e_cnt4) begin
      errors++;
      $display("FAIL gaps_cnt4 got=%0d required=%0d", r_cnt4, e_cnt4);
    end
    checks++;
    if (!(lat_ok && valid_at_m && done_ok)) begin
      errors++;
      $display("FAIL gaps_timing got=%b%b%b required=111", lat_ok, valid_at_m, done_ok);
    end
  endtask

  task automatic test_ready_hold();
    fill_equal();
    for (int k = 0; k < STEPS; k++) if ($urandom_range(0, 3) == 0) obs_a[k] = flip(gold_a[k]);
    model(16'h7777);
    run_pass(16'h7777, 0, 1, 10, 0);
    checks++;
    if (r_rec !== e_rec) begin
      errors++;
      $display("FAIL hold_rec got=%h required=%h", r_rec, e_rec);
    end
    checks++;
    if (!(hold_ok && done_ok)) begin
      errors++;
      $display("FAIL hold_stable got=%b%b required=11", hold_ok, done_ok);
    end
  endtask

  task automatic test_misr();
    for (int k = 0; k < STEPS; k++) begin
      obs_a[k] = '0; gold_a[k] = '0;
    end
    obs_a[0] = 25'h0000001; gold_a[0] = 25'h0000001;
    model(16'h00AA);
    run_pass(16'h00AA, 0, 0, 0, 0);
    checks++;
    if (r_rec[DW-1:0] !== e_rec[DW-1:0]) begin
      errors++;
      $display("FAIL misr_sig got=%h required=%h", r_rec[DW-1:0], e_rec[DW-1:0]);
    end
    // random data through the signature as well
    fill_equal();
    model(16'h00AB);
    run_pass(16'h00AB, 0, 0, 0, 0);
    checks++;
    if (r_rec !== e_rec) begin
      errors++;
      $display("FAIL misr_rand got=%h required=%h", r_rec, e_rec);
    end
  endtask

  task automatic test_reset_midrun();
    fill_equal();
    obs_a[10] = flip(gold_a[10]);
    start = 1'b1; fid = 16'h3C3C;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      obs_valid = 1'b1; obs_data = obs_a[i]; gold_data = gold_a[i];
      @(posedge clk); #1;
    end
    obs_valid = 1'b0;
    checks++;
    if (res_first_step !== 8'd10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre first=%0d busy=%b required 10/1", res_first_step, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, res_valid, res_first_step} !== {1'b0, 1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL midrun_rst busy/valid/first=%h required=0ff", {busy, res_valid, res_first_step});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_norec valid=%b busy=%b required 0/0", res_valid, busy);
    end
    fill_equal();
    model(16'h4D4D);
    run_pass(16'h4D4D, 0, 0, 0, 0);
    checks++;
    if (r_rec !== e_rec) begin
      errors++;
      $display("FAIL midrun_after got=%h required=%h", r_rec, e_rec);
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 3; p++) begin
      logic [FIDW-1:0] f;
      f = FIDW'($urandom);
      fill_equal();
      for (int k = 0; k < STEPS; k++) if ($urandom_range(0, 15) == 0) obs_a[k] = flip(gold_a[k]);
      model(f);
      run_pass(f, 1'($urandom), 0, 0, 1);
      checks++;
      if (r_rec !== e_rec || r_cnt4 !== e_cnt4) begin
        errors++;
        $display("FAIL b2b_rec%0d got=%h/%h required=%h/%h", p, r_rec, r_cnt4, e_rec, e_cnt4);
      end
      checks++;
      if (!(start_busy_ok && lat_ok && valid_at_m && done_ok)) begin
        errors++;
        $display("FAIL b2b_timing%0d got=%b%b%b%b required=1111", p,
                 start_busy_ok, lat_ok, valid_at_m, done_ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_mismatch_list();
    test_saturate();
    test_gaps_midstart();
    test_ready_hold();
    test_misr();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
